// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready handshaking on both sides.
//
//   Stage 1: forms b' (b or ~b for subtract), per-bit generate/propagate,
//            and per-group G/P. These are registered together with a, b',
//            the carry-in and the sub flag.
//   Stage 2: resolves every group carry-in by lookahead over the registered
//            group G/P, forms per-bit sums, and registers sum/cout.
//
// Parameters
//   WIDTH      operand and sum width in bits
//   GROUPSIZE  bits per lookahead group (1, 2, 4 or 8). The default comes from
//              the `GROUPSIZE macro, normally supplied by define.v; it falls
//              back to 4 when that macro is not defined.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (does not depend on in_valid)
//   a, b       operands
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum, cout  result modulo 2^WIDTH and carry out of the MSB
//              (for subtract, cout=1 means no borrow)
//
// Build option
//   PIPE_CLA_FLAGS_EN  adds outputs ovf (signed overflow) and zero (sum==0),
//                      registered alongside sum.

`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module pipe_cla_adder #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = `GROUPSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_CLA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NG = WIDTH / GROUPSIZE;

    generate
        if (!(GROUPSIZE == 1 || GROUPSIZE == 2 || GROUPSIZE == 4 || GROUPSIZE == 8)) begin : g_bad_groupsize
            $error("pipe_cla_adder: GROUPSIZE must be 1, 2, 4 or 8");
        end
        if ((WIDTH % GROUPSIZE) != 0) begin : g_bad_width
            $error("pipe_cla_adder: WIDTH must be a multiple of GROUPSIZE");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_en;

    // Stage 2 can take a new value when it is empty or being drained.
    assign s2_en    = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_en;

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning and group generate/propagate
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    logic [NG-1:0]    gg1;
    logic [NG-1:0]    gp1;

    always_comb begin
        bx  = sub ? ~b : b;
        g1  = a & bx;
        p1  = a ^ bx;
        gg1 = '0;
        gp1 = '1;
        for (int k = 0; k < NG; k++) begin
            // Group G: carry generated inside the group, folded LSB to MSB.
            for (int j = 0; j < GROUPSIZE; j++) begin
                gg1[k] = g1[k*GROUPSIZE+j] | (p1[k*GROUPSIZE+j] & gg1[k]);
                gp1[k] = gp1[k] & p1[k*GROUPSIZE+j];
            end
        end
    end

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic             s1_sub;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_sub   <= 1'b0;
            s1_gg    <= '0;
            s1_gp    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_b   <= bx;
                // Add-path carry-in only; subtract supplies its own +1 below.
                s1_cin <= cin & ~sub;
                s1_sub <= sub;
                s1_gg  <= gg1;
                s1_gp  <= gp1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: group carry lookahead and per-bit sums
    // ------------------------------------------------------------------
    logic [NG:0]      gc;
    logic [WIDTH-1:0] g2;
    logic [WIDTH-1:0] p2;
    logic [WIDTH-1:0] sum2;
    logic             cb;
`ifdef PIPE_CLA_FLAGS_EN
    logic             msb_c;
`endif

    always_comb begin
        g2 = s1_a & s1_b;
        p2 = s1_a ^ s1_b;
        gc = '0;
        // Effective carry-in: forced to 1 for subtract (two's complement +1).
        gc[0] = s1_cin | s1_sub;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = s1_gg[k] | (s1_gp[k] & gc[k]);
        end

        sum2 = '0;
        cb   = 1'b0;
`ifdef PIPE_CLA_FLAGS_EN
        msb_c = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            // Each group restarts its internal ripple from its lookahead carry.
            if ((i % GROUPSIZE) == 0) begin
                cb = gc[i/GROUPSIZE];
            end
            sum2[i] = p2[i] ^ cb;
`ifdef PIPE_CLA_FLAGS_EN
            if (i == WIDTH - 1) begin
                msb_c = cb;
            end
`endif
            cb = g2[i] | (p2[i] & cb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef PIPE_CLA_FLAGS_EN
            ovf       <= 1'b0;
            zero      <= 1'b0;
`endif
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum2;
                cout <= gc[NG];
`ifdef PIPE_CLA_FLAGS_EN
                ovf  <= msb_c ^ gc[NG];
                zero <= (sum2 == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder. Four instances (GROUPSIZE 4, 1, 2, 8)
// share the same stimulus; handshake timing does not depend on GROUPSIZE, so
// instance 0 drives the flow and every instance's result is compared against
// an arithmetic reference model.

module tb_pipe_cla_adder;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid;
    logic          cin;
    logic          sub;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    in_ready_v;
    logic [3:0]    out_valid_v;
    logic [3:0]    cout_v;
    logic [W-1:0]  sum_v [4];
`ifdef PIPE_CLA_FLAGS_EN
    logic [3:0]    ovf_v;
    logic [3:0]    zero_v;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            localparam int GS = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : 8;
            pipe_cla_adder #(.WIDTH(W), .GROUPSIZE(GS)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready_v[gi]),
                .a         (a),
                .b         (b),
                .cin       (cin),
                .sub       (sub),
                .out_valid (out_valid_v[gi]),
                .out_ready (out_ready),
                .sum       (sum_v[gi]),
                .cout      (cout_v[gi])
`ifdef PIPE_CLA_FLAGS_EN
                ,
                .ovf       (ovf_v[gi]),
                .zero      (zero_v[gi])
`endif
            );
        end
    endgenerate

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    res_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pop    = 0;
    bit   prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic prev_cout;
    logic last_rdy;
    logic last_ov;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: unbounded integer arithmetic, then truncate.
    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic su);
        res_t r;
        longint sa, sb, sr;
        logic [63:0] u;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (su) begin
            r.s = av - bv;
            r.c = (av >= bv);
            sr  = sa - sb;
        end else begin
            u   = 64'(av) + 64'(bv) + 64'(ci);
            r.s = u[W-1:0];
            r.c = u[W];
            sr  = sa + sb + longint'(64'(ci));
        end
        r.v = (sr > SMAX) || (sr < SMIN);
        r.z = (r.s == '0);
        return r;
    endfunction

    // One clock of stimulus: drive at negedge, sample 1 time unit later,
    // score any output pop and record any input accept, then let the edge pass.
    task automatic run_cycle(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic ci, input logic su, input logic orr, output logic acc);
        res_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = av;
        b         = bv;
        cin       = ci;
        sub       = su;
        out_ready = orr;
        #1;
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid_v[0]), 64'd1);
            check("hold_result", {31'd0, cout_v[0], sum_v[0]}, {31'd0, prev_cout, prev_sum});
        end
        last_rdy = in_ready_v[0];
        last_ov  = out_valid_v[0];
        if (out_valid_v[0] && orr) begin
            if (expq.size() == 0) begin
                check("spurious_out", 64'(out_valid_v[0]), 64'd0);
            end else begin
                e = expq.pop_front();
                n_pop++;
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("valid[%0d]", k), 64'(out_valid_v[k]), 64'd1);
                    check($sformatf("sum[%0d]", k), 64'(sum_v[k]), 64'(e.s));
                    check($sformatf("cout[%0d]", k), 64'(cout_v[k]), 64'(e.c));
`ifdef PIPE_CLA_FLAGS_EN
                    check($sformatf("ovf[%0d]", k), 64'(ovf_v[k]), 64'(e.v));
                    check($sformatf("zero[%0d]", k), 64'(zero_v[k]), 64'(e.z));
`endif
                end
            end
        end
        acc = iv & in_ready_v[0];
        if (acc) expq.push_back(model(av, bv, ci, su));
        prev_stall = out_valid_v[0] & ~orr;
        prev_sum   = sum_v[0];
        prev_cout  = cout_v[0];
        @(posedge clk);
    endtask

    // Single beat with fixed expected values and exact latency checks.
    task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic su, input logic [W-1:0] es,
                            input logic ec, input logic ev, input logic ez);
        @(negedge clk);
        in_valid = 1'b1; a = av; b = bv; cin = ci; sub = su; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready_v[0]), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1"}, 64'(out_valid_v[0]), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_lat2"}, 64'(out_valid_v[0]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_sum[%0d]", tag, k), 64'(sum_v[k]), 64'(es));
            check($sformatf("%s_cout[%0d]", tag, k), 64'(cout_v[k]), 64'(ec));
        end
`ifdef PIPE_CLA_FLAGS_EN
        check({tag, "_ovf"}, 64'(ovf_v[0]), 64'(ev));
        check({tag, "_zero"}, 64'(zero_v[0]), 64'(ez));
`endif
        @(negedge clk);
        #1 check({tag, "_popped"}, 64'(out_valid_v[0]), 64'd0);
    endtask

    initial begin
        logic acc;
        int   bi;
        int   accepted;
        int   cyc;
        bit   have;
        logic [W-1:0] ra, rb;
        logic rci, rsu, iv, orr;

        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rst_sum", 64'(sum_v[0]), 64'd0);
        check("rst_cout", 64'(cout_v[0]), 64'd0);
        check("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", 64'(in_ready_v[0]), 64'd1);

        directed("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("sub",  32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("cin",  32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        // Four back-to-back beats with the sink stalled in cycles 3..5.
        bi = 0;
        n_pop = 0;
        for (int c = 0; c < 12; c++) begin
            iv  = (bi < 4);
            orr = !(c >= 3 && c <= 5);
            run_cycle(iv, 32'h1111_1111 * (bi + 1), 32'h0101_0101 * (bi + 3), 1'b1, 1'(bi % 2), orr, acc);
            if (c >= 3 && c <= 5) check($sformatf("bp_in_ready_c%0d", c), 64'(last_rdy), 64'd0);
            if (acc) bi++;
        end
        check("bp_accepted", 64'(bi), 64'd4);
        check("bp_popped", 64'(n_pop), 64'd4);
        check("bp_queue_empty", 64'(expq.size()), 64'd0);

        // Reset with two beats in flight.
        run_cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, acc);
        run_cycle(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("midrst_sum", 64'(sum_v[0]), 64'd0);
        check("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        prev_stall = 1'b0;
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            check("no_out_after_rst", 64'(last_ov), 64'd0);
        end

        // Random traffic with random backpressure.
        accepted = 0;
        cyc = 0;
        have = 1'b0;
        ra = '0; rb = '0; rci = 1'b0; rsu = 1'b0;
        while (accepted < 10000 && cyc < 40000) begin
            if (!have) begin
                ra  = $urandom;
                rb  = $urandom;
                if ($urandom_range(0, 7) == 0) ra = '1;
                if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 0) ? '0 : '1;
                rci = 1'($urandom_range(0, 1));
                rsu = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            run_cycle(iv, ra, rb, rci, rsu, orr, acc);
            if (acc) begin
                accepted++;
                have = 1'b0;
            end
            cyc++;
        end
        check("rand_accepted", 64'(accepted), 64'd10000);
        for (int c = 0; c < 20 && expq.size() != 0; c++) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        end
        check("drain_empty", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter GROUPSIZE, default `GROUPSIZE from define.v: bits per lookahead group; legal values 1, 2, 4, 8.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1: 0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port out_valid, output, 1: result beat valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out of bit WIDTH-1.

Function
REQ-015 SHALL split operands into WIDTH/GROUPSIZE groups; group 0 holds bits GROUPSIZE-1:0.
REQ-016 SHALL, stage 1, compute per-bit g=a&b', p=a^b' (b' = sub ? ~b : b), per-group G/P per CLA, and register them with a/b', effective carry-in and sub flag.
REQ-017 SHALL, stage 2, compute all group carry-ins by lookahead over registered group G/P, then per-bit sums, registered into sum/cout.
REQ-018 SHALL have latency exactly 2 cycles from accepted beat (in_valid&in_ready) to out_valid with no backpressure.
REQ-019 SHALL sustain throughput of one beat per cycle while out_ready=1.
REQ-020 SHALL drive in_ready = !s1_valid | !out_valid | out_ready (combinational, no dependency on in_valid).
REQ-021 SHALL hold sum, cout, out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL hold stage-1 contents while stage 2 is stalled and full; no beat lost or duplicated.
REQ-023 SHALL, on simultaneous output pop and input accept, advance both stages in the same cycle.
REQ-024 SHALL compute results modulo 2^WIDTH; cout is bit WIDTH of the unbounded sum (for sub, cout=1 means no borrow).
REQ-025 SHALL deliver results in acceptance order.
REQ-026 SHALL fail elaboration (generate-time error) when WIDTH mod GROUPSIZE != 0 or GROUPSIZE illegal.

Reset
REQ-027 SHALL clear out_valid, stage-1 valid, sum, cout (and flags if present) to 0 on rst_n low, asynchronously.
REQ-028 SHALL drive in_ready=1 during and immediately after reset.
REQ-029 SHALL discard in-flight beats when reset asserts mid-operation; no result emerges after release without new input.

Configuration
REQ-030 SHALL support macro PIPE_CLA_FLAGS_EN; when defined, adds outputs ovf (1 bit, signed overflow: carry into MSB xor cout) and zero (1 bit, sum==0), registered with sum, same latency and stall rules.
REQ-031 SHALL, without PIPE_CLA_FLAGS_EN, have no ovf/zero ports and no flag logic.

Verification
REQ-032 SHALL cover: WIDTH=32, GROUPSIZE=4, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, out_valid 2 cycles after accept (zero=1, ovf=0 if flags).
REQ-033 SHALL cover: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1 with flags.
REQ-034 SHALL cover: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0 (cin ignored).
REQ-035 SHALL cover: 4 back-to-back beats, out_ready low cycles 3-5 -> in_ready low when both stages full, all 4 results in order, none duplicated.
REQ-036 SHALL cover: rst_n low for 1 cycle with 2 beats in flight -> out_valid=0, sum=0 immediately, no output after release.
REQ-037 SHALL cover: GROUPSIZE in {1,2,8}, 10000 random beats with random backpressure -> sum/cout match reference model A+B+cin / A-B.
